// File: rtl/leading_one_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : leading_one_scanner_pkg
//  Description : Shared state encoding and popcount helper for the
//                streaming leading-one scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package leading_one_scanner_pkg;

    // Two-state scanner control: waiting for a mask, or emitting its indices.
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    // Upper bound on mask width handled by the popcount helper; callers
    // zero-extend their mask to this width.
    localparam int POP_MAX_W = 1024;

    // Number of set bits in a zero-extended mask.
    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage : leading_one_scanner_pkg
`default_nettype wire

// File: rtl/leading_one_detector_n.sv
`default_nettype none
// ============================================================================
//  Module      : leading_one_detector_n
//  Description : Combinational priority encoder built as a balanced binary
//                tree. Reports the index of the highest-priority set bit,
//                whether any bit is set, and whether exactly one bit is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module leading_one_detector_n #(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b0,
    parameter int IDX_W     = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] mask_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o,
    output logic             single_o
);

    // Tree is built over a power-of-two padded vector stored as a heap:
    // node n has children 2n+1 (lower positions) and 2n+2 (upper positions).
    localparam int LEVELS = IDX_W;
    localparam int PAD    = 1 << IDX_W;
    localparam int NODES  = 2 * PAD - 1;

    // Mask re-ordered so that position 0 always carries the highest priority.
    logic [WIDTH-1:0] w_scan;
    logic [NODES-1:0] w_any;
    logic [NODES-1:0] w_many;
    logic [IDX_W-1:0] w_idx [NODES];
    logic [IDX_W-1:0] w_pos;

    genvar gi, gd, gk;

    for (gi = 0; gi < WIDTH; gi++) begin : g_order
        assign w_scan[gi] = LSB_FIRST ? mask_i[gi] : mask_i[WIDTH-1-gi];
    end

    // Leaves: padding positions beyond WIDTH are tied off so that unused
    // index codes can never win.
    for (gk = 0; gk < PAD; gk++) begin : g_leaf
        if (gk < WIDTH) begin : g_real
            assign w_any[PAD-1+gk] = w_scan[gk];
        end else begin : g_pad
            assign w_any[PAD-1+gk] = 1'b0;
        end
        assign w_many[PAD-1+gk] = 1'b0;
        assign w_idx[PAD-1+gk]  = '0;
    end

    // Internal nodes: the lower half wins when it has any set bit, otherwise
    // the upper half's index is offset by half this subtree's span.
    for (gd = 0; gd < LEVELS; gd++) begin : g_lvl
        for (gk = 0; gk < (1 << gd); gk++) begin : g_node
            localparam int N  = (1 << gd) - 1 + gk;
            localparam int LO = 2 * N + 1;
            localparam int HI = 2 * N + 2;
            localparam int L  = LEVELS - gd;
            assign w_any[N]  = w_any[LO] | w_any[HI];
            assign w_many[N] = w_many[LO] | w_many[HI] | (w_any[LO] & w_any[HI]);
            assign w_idx[N]  = w_any[LO] ? w_idx[LO]
                                         : (w_idx[HI] | IDX_W'(1 << (L - 1)));
        end
    end

    assign w_pos    = w_idx[0];
    assign any_o    = w_any[0];
    assign single_o = w_any[0] & ~w_many[0];
    assign idx_o    = LSB_FIRST ? w_pos : (IDX_W'(WIDTH - 1) - w_pos);

endmodule : leading_one_detector_n
`default_nettype wire

// File: rtl/leading_one_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : leading_one_scanner
//  Description : Accepts a lane mask over valid/ready and streams out the
//                index of every set bit, one per beat, in priority order.
//                All outputs are decoded from registered state only.
//  Revision    : 1.0 - initial release
// ============================================================================
module leading_one_scanner
    import leading_one_scanner_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b0,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_cnt
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             zero_q,  zero_d;

    logic             w_scan;
    logic [IDX_W-1:0] w_det_idx;
    logic             w_any;
    logic             w_single;
    logic [WIDTH-1:0] w_clr;

    leading_one_detector_n #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST),
        .IDX_W     (IDX_W)
    ) u_lod (
        .mask_i   (rem_q),
        .idx_o    (w_det_idx),
        .any_o    (w_any),
        .single_o (w_single)
    );

    // Output decode; an empty remainder (zero mask) reports index 0.
    assign w_scan    = (state_q == S_SCAN);
    assign in_ready  = ~w_scan;
    assign out_valid = w_scan;
    assign out_idx   = (w_scan & w_any) ? w_det_idx : '0;
    assign out_last  = w_scan & (w_single | ~w_any);
    assign out_zero  = w_scan & zero_q;
    assign out_cnt   = out_last ? cnt_q : '0;

    // One-hot of the bit being emitted, cleared from the remainder on accept.
    assign w_clr = {{(WIDTH-1){1'b0}}, 1'b1} << out_idx;

    // Next-state: flush overrides both handshakes.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        if (flush) begin
            state_d = S_IDLE;
            rem_d   = '0;
            cnt_d   = '0;
            zero_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_d = S_SCAN;
                        rem_d   = in_mask;
                        cnt_d   = CNT_W'(popcount(POP_MAX_W'(in_mask)));
                        zero_d  = (in_mask == '0);
                    end
                end
                S_SCAN: begin
                    if (out_ready) begin
                        rem_d = rem_q & ~w_clr;
                        if (out_last) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
        end
    end

endmodule : leading_one_scanner
`default_nettype wire
